// File: rtl/cache_pkg.sv
// Shared definitions for the cache replacement-policy slice: policy mode enum,
// flush FSM states, default geometry and the victim LFSR constants/step function.
package cache_pkg;

    typedef enum logic {
        REPL_PLRU   = 1'b0,
        REPL_RANDOM = 1'b1
    } repl_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

    localparam int unsigned NSET_DEFAULT = 16;
    localparam int unsigned NWAY_DEFAULT = 4;

    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] sh;
        sh = s >> 1;
        return s[0] ? (sh ^ LFSR_TAPS) : sh;
    endfunction

endpackage

// File: rtl/plru_tree.sv
// Combinational tree-PLRU helper.
// Bits are heap-indexed: node n (1..NWAY-1) lives at bit n-1; a 0 steers toward
// the lower half of that node's ways, a 1 toward the upper half.
// Ports:
//   vic_bits_i  tree bits of the queried set
//   vic_way_o   way reached by walking the tree from the root
//   upd_bits_i  tree bits of the touched set
//   upd_way_i   touched way
//   upd_bits_o  tree bits with the root-to-way path pointing away from upd_way_i
module plru_tree #(
    parameter int unsigned NWAY = 4
) (
    input  logic [NWAY-2:0]         vic_bits_i,
    output logic [$clog2(NWAY)-1:0] vic_way_o,
    input  logic [NWAY-2:0]         upd_bits_i,
    input  logic [$clog2(NWAY)-1:0] upd_way_i,
    output logic [NWAY-2:0]         upd_bits_o
);

    localparam int unsigned WW = $clog2(NWAY);
    localparam int unsigned NB = NWAY - 1;

    int          prefix;
    logic [NB-1:0] vic_sh;

    // Victim walk: at level l the current node is (1<<l) + way prefix so far.
    always_comb begin
        prefix = 0;
        vic_sh = '0;
        for (int l = 0; l < int'(WW); l++) begin
            vic_sh = vic_bits_i >> ((1 << l) + prefix - 1);
            prefix = (prefix << 1) | int'(vic_sh[0]);
        end
        vic_way_o = WW'(prefix);
    end

    int            upd_idx;
    int            node;
    int            way_sh;
    logic [NB-1:0] mask;

    // Touch update: each node on the path is set opposite to the branch taken.
    always_comb begin
        upd_bits_o = upd_bits_i;
        upd_idx    = int'(upd_way_i);
        node       = 1;
        way_sh     = 0;
        mask       = '0;
        for (int l = 0; l < int'(WW); l++) begin
            node   = (1 << l) + (upd_idx >> (int'(WW) - l));
            way_sh = upd_idx >> (int'(WW) - 1 - l);
            mask   = NB'(1) << (node - 1);
            upd_bits_o = way_sh[0] ? (upd_bits_o & ~mask) : (upd_bits_o | mask);
        end
    end

endmodule

// File: rtl/cache_repl_policy.sv
// Replacement-policy engine for a set-associative cache: per-set valid map and
// PLRU tree, victim selection one cycle after request, and a one-set-per-cycle
// flush sequencer.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   touch_valid/_set/_way        hit or fill; marks way valid, updates PLRU
//   inv_valid/_set/_way          invalidation; clears valid only
//   victim_req/_set              victim query
//   victim_valid/_way/_was_free  registered victim response
//   flush_req                    start a flush of all sets
//   busy                         flush in progress; other requests dropped
module cache_repl_policy
    import cache_pkg::*;
#(
    parameter int unsigned NSET = NSET_DEFAULT,
    parameter int unsigned NWAY = NWAY_DEFAULT,
    parameter int unsigned MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    touch_valid,
    input  logic [$clog2(NSET)-1:0] touch_set,
    input  logic [$clog2(NWAY)-1:0] touch_way,
    input  logic                    inv_valid,
    input  logic [$clog2(NSET)-1:0] inv_set,
    input  logic [$clog2(NWAY)-1:0] inv_way,
    input  logic                    victim_req,
    input  logic [$clog2(NSET)-1:0] victim_set,
    output logic                    victim_valid,
    output logic [$clog2(NWAY)-1:0] victim_way,
    output logic                    victim_was_free,
    input  logic                    flush_req,
    output logic                    busy
);

    localparam int unsigned SW = $clog2(NSET);
    localparam int unsigned WW = $clog2(NWAY);
    localparam bit USE_RANDOM  = (MODE == 32'(REPL_RANDOM));

    logic [NWAY-1:0]   valid_q [NSET];
    logic [NWAY-1:0]   valid_d [NSET];
    logic [NWAY-2:0]   plru_q  [NSET];
    logic [NWAY-2:0]   plru_d  [NSET];
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    flush_state_e      state_q, state_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic              victim_valid_q, victim_valid_d;
    logic [WW-1:0]     victim_way_q, victim_way_d;
    logic              victim_was_free_q, victim_was_free_d;

    logic [WW-1:0]   plru_vic_way;
    logic [NWAY-2:0] plru_upd_bits;

    plru_tree #(
        .NWAY (NWAY)
    ) u_plru_tree (
        .vic_bits_i (plru_q[victim_set]),
        .vic_way_o  (plru_vic_way),
        .upd_bits_i (plru_q[touch_set]),
        .upd_way_i  (touch_way),
        .upd_bits_o (plru_upd_bits)
    );

    logic [NWAY-1:0] vic_row;
    logic [NWAY-1:0] vic_row_sh;
    logic            free_any;
    logic [WW-1:0]   free_way;

    // Lowest-index invalid way of the queried set (pre-update state).
    always_comb begin
        vic_row    = valid_q[victim_set];
        vic_row_sh = '0;
        free_any   = 1'b0;
        free_way   = '0;
        for (int i = int'(NWAY) - 1; i >= 0; i--) begin
            vic_row_sh = vic_row >> i;
            if (!vic_row_sh[0]) begin
                free_any = 1'b1;
                free_way = WW'(i);
            end
        end
    end

    // Next-state: flush sequencer, state updates and victim response.
    always_comb begin
        valid_d           = valid_q;
        plru_d            = plru_q;
        lfsr_d            = lfsr_q;
        state_d           = state_q;
        cnt_d             = cnt_q;
        victim_valid_d    = 1'b0;
        victim_way_d      = victim_way_q;
        victim_was_free_d = victim_was_free_q;

        case (state_q)
            ST_IDLE: begin
                lfsr_d = lfsr_step(lfsr_q);
                if (touch_valid) begin
                    valid_d[touch_set][touch_way] = 1'b1;
                    if (!USE_RANDOM) begin
                        plru_d[touch_set] = plru_upd_bits;
                    end
                end
                // Applied after the touch so a same-way collision ends invalid.
                if (inv_valid) begin
                    valid_d[inv_set][inv_way] = 1'b0;
                end
                if (victim_req) begin
                    victim_valid_d    = 1'b1;
                    victim_was_free_d = free_any;
                    if (free_any) begin
                        victim_way_d = free_way;
                    end else if (USE_RANDOM) begin
                        victim_way_d = lfsr_q[WW-1:0];
                    end else begin
                        victim_way_d = plru_vic_way;
                    end
                end
                if (flush_req) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                valid_d[cnt_q] = '0;
                plru_d[cnt_q]  = '0;
                cnt_d          = cnt_q + SW'(1);
                if (cnt_q == SW'(NSET - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q           <= '{default: '0};
            plru_q            <= '{default: '0};
            lfsr_q            <= LFSR_SEED;
            state_q           <= ST_IDLE;
            cnt_q             <= '0;
            victim_valid_q    <= 1'b0;
            victim_way_q      <= '0;
            victim_was_free_q <= 1'b0;
        end else begin
            valid_q           <= valid_d;
            plru_q            <= plru_d;
            lfsr_q            <= lfsr_d;
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            victim_valid_q    <= victim_valid_d;
            victim_way_q      <= victim_way_d;
            victim_was_free_q <= victim_was_free_d;
        end
    end

    assign victim_valid    = victim_valid_q;
    assign victim_way      = victim_way_q;
    assign victim_was_free = victim_was_free_q;
    assign busy            = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_cache_repl_policy.sv
// Self-checking bench for cache_repl_policy: a PLRU instance and a random-mode
// instance share the update/flush inputs; expected victims are queued when a
// request is driven and compared when victim_valid appears.
module tb_cache_repl_policy;

    localparam int unsigned NSET = 16;
    localparam int unsigned NWAY = 4;
    localparam int unsigned SW   = 4;
    localparam int unsigned WW   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          touch_valid;
    logic [SW-1:0] touch_set;
    logic [WW-1:0] touch_way;
    logic          inv_valid;
    logic [SW-1:0] inv_set;
    logic [WW-1:0] inv_way;
    logic          victim_req;
    logic          vreq_r;
    logic [SW-1:0] victim_set;
    logic          flush_req;

    logic          vv, vf, busy;
    logic [WW-1:0] vw;
    logic          rvv, rvf, rbusy;
    logic [WW-1:0] rvw;

    cache_repl_policy #(.NSET(NSET), .NWAY(NWAY), .MODE(0)) u_dut (
        .clk(clk), .rst(rst),
        .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
        .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
        .victim_req(victim_req), .victim_set(victim_set),
        .victim_valid(vv), .victim_way(vw), .victim_was_free(vf),
        .flush_req(flush_req), .busy(busy)
    );

    cache_repl_policy #(.NSET(NSET), .NWAY(NWAY), .MODE(1)) u_dut_rnd (
        .clk(clk), .rst(rst),
        .touch_valid(touch_valid), .touch_set(touch_set), .touch_way(touch_way),
        .inv_valid(inv_valid), .inv_set(inv_set), .inv_way(inv_way),
        .victim_req(vreq_r), .victim_set(victim_set),
        .victim_valid(rvv), .victim_way(rvw), .victim_was_free(rvf),
        .flush_req(flush_req), .busy(rbusy)
    );

    typedef struct packed {
        logic [WW-1:0] way;
        logic          free;
    } exp_t;

    exp_t q_main[$];
    exp_t q_rnd[$];
    exp_t e_main, e_rnd;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   nb;
    logic [15:0] m_lfsr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference Galois LFSR (seed 0xACE1, taps 0xB400), advancing while not busy.
    always @(posedge clk) begin
        if (rst) m_lfsr <= 16'hACE1;
        else if (!rbusy) m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    end

    // Scoreboard compare, sampled on the falling edge.
    always @(negedge clk) begin
        if (vv === 1'b1) begin
            if (q_main.size() == 0) begin
                check("main_unexpected_valid", 32'(vv), 32'(0));
            end else begin
                e_main = q_main.pop_front();
                check("main_way", 32'(vw), 32'(e_main.way));
                check("main_free", 32'(vf), 32'(e_main.free));
            end
        end
        if (rvv === 1'b1) begin
            if (q_rnd.size() == 0) begin
                check("rnd_unexpected_valid", 32'(rvv), 32'(0));
            end else begin
                e_rnd = q_rnd.pop_front();
                check("rnd_way", 32'(rvw), 32'(e_rnd.way));
                check("rnd_free", 32'(rvf), 32'(e_rnd.free));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic touch(input int s, input int w);
        touch_valid = 1'b1;
        touch_set   = SW'(s);
        touch_way   = WW'(w);
        cyc();
        touch_valid = 1'b0;
    endtask

    task automatic req(input int s, input int w, input bit free);
        victim_req = 1'b1;
        victim_set = SW'(s);
        q_main.push_back(exp_t'{way: WW'(w), free: free});
        cyc();
        victim_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; touch_valid = 1'b0; touch_set = '0; touch_way = '0;
        inv_valid = 1'b0; inv_set = '0; inv_way = '0;
        victim_req = 1'b0; vreq_r = 1'b0; victim_set = '0; flush_req = 1'b0;
        repeat (3) cyc();
        check("reset_victim_valid", 32'(vv), 32'(0));
        check("reset_victim_way", 32'(vw), 32'(0));
        check("reset_was_free", 32'(vf), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        rst = 1'b0;

        // All ways invalid after reset.
        req(3, 0, 1'b1);

        // Invalid-first, then same-cycle touch invisible to the request.
        touch(3, 0); touch(3, 1); touch(3, 2);
        req(3, 3, 1'b1);
        touch_valid = 1'b1; touch_set = 4'd3; touch_way = 2'd3;
        victim_req = 1'b1; victim_set = 4'd3;
        q_main.push_back(exp_t'{way: 2'd3, free: 1'b1});
        cyc();
        touch_valid = 1'b0; victim_req = 1'b0;
        req(3, 0, 1'b0);

        // PLRU walk.
        for (int w = 0; w < 4; w++) touch(5, w);
        req(5, 0, 1'b0);
        touch(5, 0);
        req(5, 2, 1'b0);

        // Same-way collision: invalidate wins.
        touch_valid = 1'b1; touch_set = 4'd5; touch_way = 2'd1;
        inv_valid = 1'b1; inv_set = 4'd5; inv_way = 2'd1;
        cyc();
        touch_valid = 1'b0; inv_valid = 1'b0;
        req(5, 1, 1'b1);
        // Different ways in the same set: both apply.
        touch(5, 1);
        touch_valid = 1'b1; touch_set = 4'd5; touch_way = 2'd1;
        inv_valid = 1'b1; inv_set = 4'd5; inv_way = 2'd3;
        cyc();
        touch_valid = 1'b0; inv_valid = 1'b0;
        req(5, 3, 1'b1);
        touch(5, 3);
        req(5, 0, 1'b0);

        // Flush: busy length, dropped touch/request, ignored re-flush.
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        nb = 0;
        while (busy === 1'b1 && nb < 40) begin
            nb++;
            if (nb == 3) begin
                touch_valid = 1'b1; touch_set = 4'd2; touch_way = 2'd0;
                victim_req = 1'b1; victim_set = 4'd2; flush_req = 1'b1;
            end else begin
                touch_valid = 1'b0; victim_req = 1'b0; flush_req = 1'b0;
            end
            cyc();
            if (nb == 3) check("victim_valid_during_busy", 32'(vv), 32'(0));
        end
        touch_valid = 1'b0; victim_req = 1'b0; flush_req = 1'b0;
        check("busy_cycles", 32'(nb), 32'(16));
        for (int s = 0; s < 16; s++) req(s, 0, 1'b1);

        // Reset during flush cycle 4 aborts it.
        flush_req = 1'b1;
        cyc();
        flush_req = 1'b0;
        repeat (3) cyc();
        check("busy_before_abort", 32'(busy), 32'(1));
        rst = 1'b1;
        cyc();
        check("busy_after_abort", 32'(busy), 32'(0));
        rst = 1'b0;
        req(0, 0, 1'b1);

        // Random mode: full set, victims follow the reference LFSR.
        for (int w = 0; w < 4; w++) touch(7, w);
        for (int i = 0; i < 10; i++) begin
            vreq_r = 1'b1;
            victim_set = 4'd7;
            q_rnd.push_back(exp_t'{way: m_lfsr[1:0], free: 1'b0});
            cyc();
        end
        vreq_r = 1'b0;

        repeat (3) cyc();
        check("main_queue_drained", 32'(q_main.size()), 32'(0));
        check("rnd_queue_drained", 32'(q_rnd.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_repl_policy.md
# cache_repl_policy

Parametrised replacement-policy engine for the set-associative caches. It tracks a per-set valid map and replacement state, and returns a victim way for a requested set one cycle after the request. The victim is the lowest-index invalid way first; otherwise tree-PLRU or LFSR-random, chosen by `MODE`. It sits beside the cache tag array: the cache controller reports every hit/fill (touch) and every invalidation, and queries a victim on each miss. It also provides a multi-cycle flush sequencer.

## Interface
- `NSET`, 16, number of sets; power of 2, ≥2.
- `NWAY`, 4, ways per set; power of 2, 2..16.
- `MODE`, 0, policy: 0 = tree-PLRU, 1 = LFSR random.
- Derived: `SW = $clog2(NSET)`, `WW = $clog2(NWAY)`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `touch_valid`  in  1  hit or fill of `touch_set`/`touch_way`.
- `touch_set`  in  SW  set of the touch.
- `touch_way`  in  WW  way of the touch.
- `inv_valid`  in  1  invalidate `inv_set`/`inv_way`.
- `inv_set`  in  SW  set of the invalidation.
- `inv_way`  in  WW  way of the invalidation.
- `victim_req`  in  1  victim query for `victim_set`.
- `victim_set`  in  SW  set being queried.
- `victim_valid`  out  1  registered; pulses 1 cycle after an accepted request.
- `victim_way`  out  WW  registered victim way.
- `victim_was_free`  out  1  registered; victim came from an invalid way.
- `flush_req`  in  1  start a flush of all sets.
- `busy`  out  1  flush in progress.

## Operation
- **State per set:**
  - `valid[NWAY]`.
  - `plru[NWAY-1]`: heap-indexed tree, node 1 is the root, node n has children 2n and 2n+1.
  - A node bit of 0 steers the victim to the lower half of that node's ways; 1 steers it to the upper half.
- **Touch:**
  - Sets `valid[way]`.
  - In MODE 0, sets every node on the root-to-way path to point away from the touched way.
  - In MODE 1, the PLRU bits are not kept (they may be optimised out).
- **Invalidate:** clears `valid[way]`. PLRU bits are unchanged.
- **Simultaneous touch and invalidate:**
  - Same set, same way: the invalidate wins, so valid ends at 0. The PLRU path update still applies.
  - Same set, different ways: both updates apply.
- **Victim:**
  - Computed from the state before the current cycle's touch/invalidate updates.
  - If any way is invalid, the lowest invalid index is chosen and `victim_was_free`=1.
  - Otherwise MODE 0 walks the tree from the root; MODE 1 uses `lfsr[WW-1:0]`.
- **LFSR:** 16-bit Galois, taps 0xB400, seed 16'hACE1 on reset. It advances every cycle that `busy`=0.
- **Flush FSM:**
  - States are `IDLE` and `FLUSH`.
  - `IDLE`→`FLUSH` on `flush_req`. A set counter is loaded with 0 and `busy` rises next cycle.
  - In `FLUSH`, one set per cycle has its valid bits and PLRU bits cleared and the counter increments.
  - After set NSET-1 the FSM returns to `IDLE`, so `busy` is high exactly NSET cycles.
  - While `busy`: touch, invalidate and `victim_req` are ignored (dropped, not queued), `victim_valid` stays 0, and `flush_req` is ignored.
- **Reset values:**
  - All valid bits, PLRU bits and outputs are 0, with the FSM in `IDLE`.
  - `rst` mid-flush aborts the flush; `busy`=0 the next cycle.

## Timing
- Victim latency is 1 cycle: request in cycle N, `victim_valid`/`victim_way`/`victim_was_free` in cycle N+1. Back-to-back requests are accepted every cycle.
- A touch or invalidate in cycle N is visible to a victim request in cycle N+1, and not to one in cycle N.
- A `flush_req` in cycle N (with `busy`=0) makes `busy` 1 in cycles N+1..N+NSET.
- A victim request in cycle N+NSET+1 sees all ways invalid.
- No internal combinational path from the inputs to the outputs.

## Structure
- Package `cache_pkg` holds:
  - `repl_mode_e` (`REPL_PLRU`, `REPL_RANDOM`).
  - The LFSR seed and tap constants.
  - Shared `NSET`/`NWAY` defaults, matching the cache.
- One sub-module, `plru_tree`, is combinational and parametrised by NWAY. It has two functions:
  - Victim-from-bits.
  - Next-bits-on-touch.
- Valid and PLRU storage are flops, not SRAM, to allow single-cycle flush-per-set and concurrent read/update.

## Test plan
Defaults NSET=16, NWAY=4, MODE=0 unless stated.
1. **All invalid after reset:** after reset, `victim_req` on set 3 → next cycle `victim_valid`=1, way 0, `victim_was_free`=1.
2. **Invalid-first:** touch set 3 ways 0, 1, 2, then request set 3 → way 3, `was_free`=1.
3. **PLRU walk:**
   - Touch set 5 ways 0, 1, 2, 3 in order, then request → way 0, `was_free`=0.
   - Then touch way 0 and request → way 2.
4. **Touch/invalidate collision:**
   - Set 5 fully valid.
   - Same cycle: touch way 1 and invalidate way 1.
   - Request next cycle → way 1, `was_free`=1.
5. **Flush:**
   - `flush_req` → `busy` high exactly 16 cycles.
   - A touch during `busy` is dropped.
   - Afterwards, every set returns way 0 with `was_free`=1.
   - `rst` at flush cycle 4 → `busy`=0 the next cycle.
6. **Random mode:** MODE=1, all ways valid. Ten consecutive requests return ways matching a reference Galois LFSR (seed 0xACE1) low 2 bits cycle-for-cycle.
